alu_issue_stage: RTL

- Two-stage pipelined issue/capture stage directly upstream of the combinational 32-bit ALU (f encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; zero flag).
- Accepts decoded-instruction operands over valid/ready and translates aluop/funct into the 3-bit ALU control.
- Holds a, b and f stable into the ALU, then registers out and zero into a result register that presents them downstream with valid/ready backpressure.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_decoder.sv | 35 +++
 rtl/alu_issue_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control encodings, aluop/funct codes and decoded-op type
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] OP_LDST  = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic [2:0] f;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational aluop/funct to ALU control translation with illegal flag
module alu_decoder
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] f,
    output logic       illegal
);

    dec_t d;

    // unknown funct or reserved aluop falls back to add so the ALU still sees a defined op
    always_comb begin
        d = '{f: ALU_ADD, illegal: 1'b0};
        case (aluop)
            OP_LDST:   d.f = ALU_ADD;
            OP_BRANCH: d.f = ALU_SUB;
            OP_RTYPE:
                case (funct)
                    FN_ADD:  d.f = ALU_ADD;
                    FN_SUB:  d.f = ALU_SUB;
                    FN_AND:  d.f = ALU_AND;
                    FN_OR:   d.f = ALU_OR;
                    FN_SLT:  d.f = ALU_SLT;
                    default: d.illegal = 1'b1;
                endcase
            default:   d.illegal = 1'b1;
        endcase
    end

    assign f       = d.f;
    assign illegal = d.illegal;

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage operand issue and result capture around an external ALU
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_aluop,
    input  logic [5:0]       in_funct,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] illegal_count
);

    logic             s1_valid, s1_illegal, s2_valid;
    logic [TAG_W-1:0] s1_tag;
    logic [2:0]       dec_f;
    logic             dec_illegal, s1_adv, accept, out_hs;

    alu_decoder u_dec (
        .aluop   (in_aluop),
        .funct   (in_funct),
        .f       (dec_f),
        .illegal (dec_illegal)
    );

    assign s1_adv    = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | s1_adv;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_valid;
    assign out_hs    = s2_valid & out_ready;

    // stage 1: holds operands and control steady in front of the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_f      <= ALU_AND;
            s1_illegal <= 1'b0;
            s1_tag     <= '0;
        end else begin
            s1_valid <= accept | (s1_valid & ~s1_adv);
            if (accept) begin
                alu_a      <= in_a;
                alu_b      <= in_b;
                alu_f      <= dec_f;
                s1_illegal <= dec_illegal;
                s1_tag     <= in_tag;
            end
        end
    end

    // stage 2: captures the ALU result when stage 1 advances, holds it under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else begin
            s2_valid <= s1_adv | (s2_valid & ~out_ready);
            if (s1_adv) begin
                out_result  <= alu_out;
                out_zero    <= alu_zero;
                out_illegal <= s1_illegal;
                out_tag     <= s1_tag;
            end
        end
    end

    // saturating handshake statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count      <= '0;
            illegal_count <= '0;
        end else begin
            if (out_hs && !(&op_count))
                op_count <= op_count + 1'b1;
            if (out_hs && out_illegal && !(&illegal_count))
                illegal_count <= illegal_count + 1'b1;
        end
    end

endmodule
